// File: rtl/mac_acc_pkg.sv
// Shared types and size helpers for the nibble-serial MAC accumulator.
package mac_acc_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RECV  = 3'd1,
        DRAIN = 3'd2,
        SEND  = 3'd3,
        DONE  = 3'd4
    } state_t;

    typedef enum logic {
        MODE_ACC = 1'b0,
        MODE_MAC = 1'b1
    } mode_t;

    // Nibbles per operand.
    function automatic int nib_count(input int bit_width);
        return bit_width / 4;
    endfunction

    // Nibbles per streamed result.
    function automatic int out_nib_count(input int acc_width);
        return acc_width / 4;
    endfunction

endpackage

// File: rtl/acc_sat_adder.sv
// Guard-bit accumulator adder: extends the running sum, adds one term,
// flags results that do not fit in ACC_WIDTH and optionally clamps them.
module acc_sat_adder
#(
    parameter int ACC_WIDTH = 72,
    parameter int SIGNED    = 0,
    parameter int SATURATE  = 0
)
(
    input  logic [ACC_WIDTH-1:0] acc,
    input  logic [ACC_WIDTH:0]   term,
    output logic [ACC_WIDTH-1:0] sum,
    output logic                 ovf
);

    logic [ACC_WIDTH:0] acc_x;
    logic [ACC_WIDTH:0] sum_x;

    // Extend, add, detect overflow from the guard bit, then wrap or clamp.
    always_comb begin
        acc_x = (SIGNED != 0) ? {acc[ACC_WIDTH-1], acc} : {1'b0, acc};
        sum_x = acc_x + term;
        ovf   = (SIGNED != 0) ? (sum_x[ACC_WIDTH] != sum_x[ACC_WIDTH-1]) : sum_x[ACC_WIDTH];
        sum   = sum_x[ACC_WIDTH-1:0];
        if (ovf && (SATURATE != 0)) begin
            if (SIGNED == 0)
                sum = '1;
            else if (sum_x[ACC_WIDTH])
                sum = {1'b1, {(ACC_WIDTH-1){1'b0}}};
            else
                sum = {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end
    end

endmodule

// File: rtl/serial_mac_accumulator.sv
// Nibble-serial accumulate / multiply-accumulate engine. Operands arrive
// LSB nibble first; each completed term is registered and added one cycle
// later, and the final sum is streamed back LSB nibble first.
module serial_mac_accumulator
    import mac_acc_pkg::*;
#(
    parameter int BIT_WIDTH = 32,
    parameter int ACC_WIDTH = 2*BIT_WIDTH+8,
    parameter int SIGNED    = 0,
    parameter int SATURATE  = 0
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       mode,
    input  logic [3:0] data_in,
    output logic [3:0] data_out,
    output logic       data_out_valid,
    output logic       result_complete,
    output logic       overflow,
    output logic       ready
);

    localparam int NIB  = nib_count(BIT_WIDTH);
    localparam int ONIB = out_nib_count(ACC_WIDTH);
    localparam int MAXC = (2*NIB > ONIB) ? 2*NIB : ONIB;
    localparam int CW   = (MAXC > 2) ? $clog2(MAXC) : 1;
    localparam int XW   = (ACC_WIDTH+1 > 2*BIT_WIDTH+2) ? ACC_WIDTH+1 : 2*BIT_WIDTH+2;

    state_t                       state, state_nxt;
    mode_t                        mode_q, eff_mode;
    logic [CW-1:0]                cnt, cnt_nxt, last_idx;
    logic [BIT_WIDTH-1:0]         a_sr, b_sr, nib_a, nib_b, op_a;
    logic [ACC_WIDTH-1:0]         acc, sum;
    logic [ACC_WIDTH:0]           term_q;
    logic                         term_vld, ovf_q, ready_q, add_ovf;
    logic                         idle_like, begin_s, nib_en, last_nib, to_b;
    logic signed [BIT_WIDTH:0]    a_x, b_x;
    logic signed [2*BIT_WIDTH+1:0] prod;
    logic signed [XW-1:0]         term_x;

    // Nibble steering and term formation; the session's mode comes straight
    // from the port on the start cycle, from the latched copy afterwards.
    always_comb begin
        idle_like = (state == IDLE) || (state == DONE);
        begin_s   = idle_like && start;
        nib_en    = begin_s || (state == RECV);
        eff_mode  = idle_like ? mode_t'(mode) : mode_q;
        last_idx  = (eff_mode == MODE_MAC) ? CW'(2*NIB-1) : CW'(NIB-1);
        last_nib  = (cnt == last_idx);
        to_b      = (eff_mode == MODE_MAC) && (cnt >= CW'(NIB));
        nib_a     = BIT_WIDTH'({data_in, a_sr} >> 4);
        nib_b     = BIT_WIDTH'({data_in, b_sr} >> 4);
        op_a      = (eff_mode == MODE_MAC) ? a_sr : nib_a;
        a_x       = (SIGNED != 0) ? {op_a[BIT_WIDTH-1], op_a} : {1'b0, op_a};
        b_x       = (SIGNED != 0) ? {nib_b[BIT_WIDTH-1], nib_b} : {1'b0, nib_b};
        prod      = a_x * b_x;
        term_x    = (eff_mode == MODE_MAC) ? XW'(prod) : XW'(a_x);
    end

    acc_sat_adder #(
        .ACC_WIDTH (ACC_WIDTH),
        .SIGNED    (SIGNED),
        .SATURATE  (SATURATE)
    ) u_adder (
        .acc  (acc),
        .term (term_q),
        .sum  (sum),
        .ovf  (add_ovf)
    );

    // Next-state and shared nibble counter (term position in RECV, result
    // nibble index in SEND; it always returns to zero between phases).
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = RECV;
                    cnt_nxt   = last_nib ? '0 : CW'(1);
                end else begin
                    state_nxt = IDLE;
                end
            end
            RECV: begin
                cnt_nxt = last_nib ? '0 : cnt + 1'b1;
                if (last_nib && start)
                    state_nxt = DRAIN;
            end
            DRAIN: state_nxt = SEND;
            SEND: begin
                if (cnt == CW'(ONIB-1)) begin
                    state_nxt = DONE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // State, operand shift registers, term pipeline register and accumulator.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            mode_q   <= MODE_ACC;
            cnt      <= '0;
            a_sr     <= '0;
            b_sr     <= '0;
            acc      <= '0;
            term_q   <= '0;
            term_vld <= 1'b0;
            ovf_q    <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            ready_q  <= (state_nxt == IDLE) || (state_nxt == DONE);
            term_vld <= nib_en && last_nib;
            if (nib_en && last_nib)
                term_q <= (ACC_WIDTH+1)'(term_x);
            if (nib_en) begin
                if (to_b) b_sr <= nib_b;
                else      a_sr <= nib_a;
            end
            if (begin_s) begin
                mode_q <= eff_mode;
                acc    <= '0;
                ovf_q  <= 1'b0;
            end else if (term_vld) begin
                acc <= sum;
                if (add_ovf) ovf_q <= 1'b1;
            end
        end
    end

    // Result stream is a direct view of the settled accumulator.
    always_comb begin
        data_out_valid  = (state == SEND);
        result_complete = (state == DONE);
        data_out        = data_out_valid ? 4'(acc >> {cnt, 2'b00}) : 4'h0;
        overflow        = ovf_q;
        ready           = ready_q;
    end

endmodule

// File: tb/tb_serial_mac_accumulator.sv
// Directed bench: four parameterisations share one input stream; session
// vectors come from a table, back-to-back start and mid-SEND reset are
// hand-written sequences.
module tb_serial_mac_accumulator;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic mode = 1'b0;
    logic [3:0] data_in = 4'h0;

    wire [3:0][3:0] dout;
    wire [3:0] dv, rc, ov, rdy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // 0: unsigned 24b, 1: signed 24b, 2: unsigned saturating 8b, 3: unsigned wrapping 8b
    serial_mac_accumulator #(.BIT_WIDTH(8), .ACC_WIDTH(24), .SIGNED(0), .SATURATE(0)) u_u (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .data_in(data_in),
        .data_out(dout[0]), .data_out_valid(dv[0]), .result_complete(rc[0]),
        .overflow(ov[0]), .ready(rdy[0]));
    serial_mac_accumulator #(.BIT_WIDTH(8), .ACC_WIDTH(24), .SIGNED(1), .SATURATE(0)) u_s (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .data_in(data_in),
        .data_out(dout[1]), .data_out_valid(dv[1]), .result_complete(rc[1]),
        .overflow(ov[1]), .ready(rdy[1]));
    serial_mac_accumulator #(.BIT_WIDTH(8), .ACC_WIDTH(8), .SIGNED(0), .SATURATE(1)) u_sat (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .data_in(data_in),
        .data_out(dout[2]), .data_out_valid(dv[2]), .result_complete(rc[2]),
        .overflow(ov[2]), .ready(rdy[2]));
    serial_mac_accumulator #(.BIT_WIDTH(8), .ACC_WIDTH(8), .SIGNED(0), .SATURATE(0)) u_wrap (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .data_in(data_in),
        .data_out(dout[3]), .data_out_valid(dv[3]), .result_complete(rc[3]),
        .overflow(ov[3]), .ready(rdy[3]));

    typedef struct {
        bit               mac;
        int               n;
        logic [2:0][7:0]  a;
        logic [2:0][7:0]  b;
        bit               junk;   // extra start on A's last nibble of term 0
        bit               chk8;   // also check the 8-bit instances
        logic [3:0][23:0] exp;
        logic [3:0]       eovf;
    } vec_t;

    vec_t vt [6];
    vec_t vb;

    function automatic vec_t mk(input bit mac, input int n,
                                input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] a2,
                                input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                                input bit junk, input bit chk8,
                                input logic [23:0] eu, input logic [23:0] es,
                                input logic [23:0] esat, input logic [23:0] ewrap,
                                input logic [3:0] eovf);
        vec_t v;
        v.mac  = mac;
        v.n    = n;
        v.a    = {a2, a1, a0};
        v.b    = {b2, b1, b0};
        v.junk = junk;
        v.chk8 = chk8;
        v.exp  = {ewrap, esat, es, eu};
        v.eovf = eovf;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %h expected %h", name, idx, act, exp);
        end
    endtask

    // Drive every nibble of a session; returns in the cycle after the final nibble.
    task automatic drive_vec(input vec_t v);
        for (int t = 0; t < v.n; t++) begin
            for (int k = 0; k < (v.mac ? 4 : 2); k++) begin
                logic [7:0] op;
                op      = (k < 2) ? v.a[t] : v.b[t];
                data_in = op[4*(k%2) +: 4];
                mode    = v.mac;
                start   = (t == 0 && k == 0) || (t == v.n-1 && k == (v.mac ? 3 : 1)) ||
                          (v.junk && t == 0 && k == 1);
                @(posedge clk); #1;
            end
        end
        start   = 1'b0;
        data_in = 4'h0;
    endtask

    // Observe cycles T+1..T+8 and compare the streamed results.
    task automatic collect(input vec_t v, input bit btb);
        logic [3:0][23:0] cap;
        logic [3:0][8:0]  vm, cm;
        logic [3:0]       ovc;
        cap = '0; vm = '0; cm = '0; ovc = '0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                vm[i][c] = dv[i];
                cm[i][c] = rc[i];
                if (dv[i] && c >= 2 && c <= 7) cap[i][4*(c-2) +: 4] = dout[i];
                if (rc[i]) ovc[i] = ov[i];
            end
            if (c == 8 && btb) begin
                start   = 1'b1;
                data_in = 4'h7;
                mode    = 1'b0;
            end
            @(posedge clk); #1;
        end
        for (int i = 0; i < 4; i++) begin
            if (i < 2 || v.chk8) begin
                check("valid_window", i, 32'(vm[i]), (i < 2) ? 32'h0FC : 32'h00C);
                check("complete_cycle", i, 32'(cm[i]), (i < 2) ? 32'h100 : 32'h010);
                check("result", i, 32'(cap[i]), 32'(v.exp[i]));
                check("overflow", i, 32'(ovc[i]), 32'(v.eovf[i]));
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] saw_v, saw_c;
        //             mac n  a0     a1     a2     b0     b1     b2    junk chk8  u          s          sat        wrap       ovf{w,sat,s,u}
        vt[0] = mk(0, 3, 8'h12, 8'h34, 8'hFF, 8'h00, 8'h00, 8'h00, 0, 1, 24'h000145, 24'h000045, 24'h0000FF, 24'h000045, 4'b1100);
        vt[1] = mk(1, 2, 8'h03, 8'h10, 8'h00, 8'h05, 8'h10, 8'h00, 1, 0, 24'h00010F, 24'h00010F, 24'h0, 24'h0, 4'b0000);
        vt[2] = mk(1, 2, 8'hFE, 8'h01, 8'h00, 8'h03, 8'h01, 8'h00, 0, 0, 24'h0002FB, 24'hFFFFFB, 24'h0, 24'h0, 4'b0000);
        vt[3] = mk(0, 2, 8'hF0, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 24'h000110, 24'h000010, 24'h0000FF, 24'h000010, 4'b1100);
        vt[4] = mk(0, 2, 8'h80, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 24'h000100, 24'hFFFF00, 24'h0000FF, 24'h000000, 4'b1100);
        vt[5] = mk(1, 2, 8'hFF, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'h00, 0, 0, 24'h01FC02, 24'h000002, 24'h0, 24'h0, 4'b0000);
        vb    = mk(0, 1, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 24'h000007, 24'h000007, 24'h000007, 24'h000007, 4'b0000);

        // Reset state while rst is held
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            check("rst_ready", i, 32'(rdy[i]), 32'h0);
            check("rst_valid", i, 32'(dv[i]), 32'h0);
            check("rst_complete", i, 32'(rc[i]), 32'h0);
            check("rst_overflow", i, 32'(ov[i]), 32'h0);
            check("rst_data_out", i, 32'(dout[i]), 32'h0);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        check("ready_after_rst", 0, 32'(rdy[0]), 32'h1);

        // Table-driven sessions
        for (int v = 0; v < 6; v++) begin
            drive_vec(vt[v]);
            collect(vt[v], 1'b0);
        end

        // Zero-gap restart in the result_complete cycle after an overflowing session
        drive_vec(vt[3]);
        collect(vt[3], 1'b1);
        data_in = 4'h0;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        collect(vb, 1'b0);

        // Reset during the 3rd SEND cycle
        drive_vec(vt[3]);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("abort_valid", i, 32'(dv[i]), 32'h0);
            check("abort_complete", i, 32'(rc[i]), 32'h0);
            check("abort_ready", i, 32'(rdy[i]), 32'h0);
            check("abort_overflow", i, 32'(ov[i]), 32'h0);
        end
        @(posedge clk); #1;
        check("abort_ready_after", 0, 32'(rdy[0]), 32'h1);
        saw_v = '0;
        saw_c = '0;
        repeat (6) begin
            @(negedge clk);
            saw_v = saw_v | dv;
            saw_c = saw_c | rc;
        end
        @(posedge clk); #1;
        check("abort_no_valid", 0, 32'(saw_v), 32'h0);
        check("abort_no_complete", 0, 32'(saw_c), 32'h0);
        drive_vec(vt[0]);
        collect(vt[0], 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_mac_accumulator.md
# serial_mac_accumulator

Nibble-serial multiply-accumulate engine and the parametrised successor to the 4-bit-port accumulator. It takes operands LSB-nibble-first on a 4-bit port. A mode input selects the term type: either each operand is one term (plain accumulate), or operand pairs are multiplied and the product is one term. The running sum is held with guard bits, with optional signed arithmetic, sticky overflow and saturation. The result is streamed back nibble-serially.

## Interface
- BIT_WIDTH, 32, operand width; multiple of 4, ≥4
- ACC_WIDTH, 2*BIT_WIDTH+8, accumulator/result width; multiple of 4, ≥BIT_WIDTH
- SIGNED, 0, 1 = two's-complement operands and sum
- SATURATE, 0, 1 = clamp sum to ACC_WIDTH range on overflow
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begins session (IDLE/DONE), or ends it when high on the last nibble of a term
- mode  in  1  0 = ACC (term = operand), 1 = MAC (term = A×B); sampled only when a session starts
- data_in  in  4  operand nibble, LSB first
- data_out  out  4  result nibble, LSB first
- data_out_valid  out  1  data_out carries a result nibble
- result_complete  out  1  one-cycle pulse after the last result nibble
- overflow  out  1  sticky overflow for the session; valid together with data_out_valid and result_complete
- ready  out  1  idle or done; may start a session

## Operation
- States: IDLE, RECV, DRAIN, SEND, DONE.
- IDLE/DONE with start=1 does the following:
  - latches mode
  - clears the accumulator and overflow
  - captures data_in as nibble 0 of the first operand
  - goes to RECV
- DONE with start=0 goes to IDLE.
- RECV shifts in nibbles:
  - Term length is NIB = BIT_WIDTH/4 cycles in ACC mode, or 2·NIB cycles in MAC mode (A then B).
  - The nibble counter wraps at term end.
- Start is ignored in RECV except on the last nibble of a term. In MAC mode this means B's last nibble; start on A's last nibble is ignored. A qualifying start goes to DRAIN.
- Term arithmetic:
  - Operands are zero-extended, or sign-extended when SIGNED=1.
  - The MAC product is the full 2·BIT_WIDTH product.
  - The term is extended or truncated to ACC_WIDTH+1 bits for the add.
- Overflow: the result does not fit in ACC_WIDTH. This is the carry-out when unsigned, or a sign mismatch of the extended sum when signed.
  - On overflow, overflow is set and stays set until the next session start.
  - With SATURATE=1 the accumulator clamps to max/min. With SATURATE=0 it wraps modulo 2^ACC_WIDTH.
- DRAIN lasts one cycle and commits the final term. SEND lasts OUT_NIB = ACC_WIDTH/4 cycles, then the block goes to DONE (one cycle).
- Start during DRAIN or SEND is ignored.

## Timing
- Term commit is pipelined: the operand register is filled at the edge ending the term's last nibble cycle. The term is added at the following edge. Back-to-back terms never stall.
- Final nibble at cycle T (start=1) gives:
  - data_out_valid high in cycles T+2 … T+1+OUT_NIB
  - data_out = accumulator nibble k in cycle T+2+k
  - result_complete=1 and ready=1 in cycle T+2+OUT_NIB
  - overflow stable from T+2 through T+2+OUT_NIB
- Start in the result_complete cycle begins a new session with zero gap; that cycle's data_in is nibble 0.
- ready is high in IDLE and DONE, low otherwise.
- Reset values (cycle after rst sampled high): state IDLE, accumulator 0, counter 0, data_out 0, data_out_valid 0, result_complete 0, overflow 0, ready 0.
  - ready=1 from the first cycle after rst is sampled low.
  - rst high in any state, including mid-RECV or mid-SEND, aborts the session with no further valid nibbles.

## Structure
- Package mac_acc_pkg holds:
  - state_t enum (IDLE, RECV, DRAIN, SEND, DONE)
  - mode_t enum (MODE_ACC, MODE_MAC)
  - NIB/OUT_NIB helper functions
- Sub-module acc_sat_adder: combinational extend + add + overflow detect + optional clamp, parametrised by ACC_WIDTH/SIGNED/SATURATE.
- Top holds the FSM, nibble counter, operand shift registers, multiplier and output mux.

## Test plan
All cases use BIT_WIDTH=8 and ACC_WIDTH=24 (OUT_NIB=6) unless noted.
- ACC, unsigned, operands 0x12, 0x34, 0xFF, start on last nibble of 0xFF -> nibbles 5,4,1,0,0,0 (0x000145), overflow=0, result_complete at T+8.
- MAC, unsigned, 3×5 then 0x10×0x10 -> 0x00010F, nibbles F,0,1,0,0,0. Start on A's last nibble is ignored and the session continues.
- MAC, SIGNED=1, (−2)×3 then 1×1 -> 0xFFFFFB (−5), nibbles B,F,F,F,F,F, overflow=0.
- ACC with ACC_WIDTH=8, 0xF0+0x20:
  - SATURATE=1 -> 0xFF, overflow=1
  - SATURATE=0 -> 0x10, overflow=1
- Start asserted in the result_complete cycle with data_in=0x7, then session ACC 0x07 -> second result 0x000007. Accumulator and overflow are cleared, no idle gap.
- rst pulsed during the 3rd SEND cycle -> data_out_valid=0 in the cycle after rst is sampled, no result_complete, ready=1 the cycle after rst drops. A new session then produces a correct result.
